// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control FSM; optional PERF_CNT_EN adds cycle/instret counters
module mc_control #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             target_we,
  output logic             addr_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             illegal,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic [3:0]       state_o
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_MEM   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_I   = 4'd6,
    EXEC_R   = 4'd7,
    WB_ALU   = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_t;
  state_t     r_state, w_next;
  logic [6:0] w_op;
  logic       w_legal, w_ok;
  logic       r_illegal, r_fetch, r_branch, r_target_we, r_addr_we;
  logic       r_mem_req, r_mem_we, r_mem_addr_sel, r_reg_we, r_wb_sel;
  logic [1:0] r_alu_src_a, r_alu_src_b, r_alu_op;
  assign w_op    = instr[6:0];
  assign w_legal = w_op inside {7'h03, 7'h23, 7'h13, 7'h33, 7'h63};
  // next state; reset always steers to FETCH so the registered outputs land on FETCH values
  always_comb begin
    w_next = FETCH;
    if (rst_n)
      case (r_state)
        FETCH:    w_next = mem_ready ? DECODE : FETCH;
        DECODE:   w_next = (w_op == 7'h03 || w_op == 7'h23) ? MEM_ADDR :
                           (w_op == 7'h13) ? EXEC_I :
                           (w_op == 7'h33) ? EXEC_R :
                           (w_op == 7'h63) ? BRANCH :
                           ILLEGAL_HALT ? TRAP : FETCH;
        MEM_ADDR: w_next = instr[5] ? MEM_WR : MEM_RD;
        MEM_RD:   w_next = mem_ready ? WB_MEM : MEM_RD;
        MEM_WR:   w_next = mem_ready ? FETCH : MEM_WR;
        EXEC_I:   w_next = WB_ALU;
        EXEC_R:   w_next = WB_ALU;
        TRAP:     w_next = TRAP;
        default:  w_next = FETCH;
      endcase
  end
  // state, sticky illegal flag and Moore outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | (r_state == DECODE && !w_legal);
    end
    r_fetch        <= w_next == FETCH;
    r_branch       <= w_next == BRANCH;
    r_target_we    <= w_next == DECODE;
    r_addr_we      <= w_next == MEM_ADDR;
    r_mem_req      <= w_next inside {FETCH, MEM_RD, MEM_WR};
    r_mem_we       <= w_next == MEM_WR;
    r_mem_addr_sel <= w_next inside {MEM_RD, MEM_WR};
    r_alu_src_a    <= (w_next == FETCH) ? 2'd1 : (w_next == DECODE) ? 2'd2 : 2'd0;
    r_alu_src_b    <= (w_next == FETCH) ? 2'd2 : (w_next inside {DECODE, MEM_ADDR, EXEC_I}) ? 2'd1 : 2'd0;
    r_alu_op       <= (w_next inside {EXEC_I, EXEC_R}) ? 2'b10 : (w_next == BRANCH) ? 2'b01 : 2'b00;
    r_reg_we       <= (w_next inside {WB_MEM, WB_ALU}) && instr[11:7] != 5'd0;
    r_wb_sel       <= w_next == WB_MEM;
  end
  // reset and unreachable encodings silence every output; memory/branch gating stays combinational
  assign w_ok         = rst_n && r_state <= TRAP;
  assign ir_we        = w_ok & r_fetch & mem_ready;
  assign pc_we        = w_ok & ((r_fetch & mem_ready) | (r_branch & br_taken));
  assign pc_sel       = w_ok & r_branch;
  assign target_we    = w_ok & r_target_we;
  assign addr_we      = w_ok & r_addr_we;
  assign mem_req      = w_ok & r_mem_req;
  assign mem_we       = w_ok & r_mem_we;
  assign mem_addr_sel = w_ok & r_mem_addr_sel;
  assign alu_src_a    = w_ok ? r_alu_src_a : 2'd0;
  assign alu_src_b    = w_ok ? r_alu_src_b : 2'd0;
  assign alu_op       = w_ok ? r_alu_op : 2'd0;
  assign reg_we       = w_ok & r_reg_we;
  assign wb_sel       = w_ok & r_wb_sel;
  assign illegal      = r_illegal;
  assign state_o      = r_state;
  logic w_unused;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt, r_instret_cnt;
  logic             w_retire;
  assign w_retire = (r_state inside {WB_MEM, WB_ALU, BRANCH}) || (r_state == MEM_WR && mem_ready) ||
                    (r_state == DECODE && !w_legal && !ILLEGAL_HALT);
  // free-running cycle count and retired-instruction count, both wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt   <= r_cycle_cnt + 1'b1;
      r_instret_cnt <= r_instret_cnt + CNT_W'(w_retire);
    end
  end
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
  assign w_unused    = ^instr[31:12];
`else
  assign w_unused    = ^{instr[31:12], CNT_W > 0};
`endif
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized scoreboard bench for mc_control with directed corner cases
module tb_mc_control;
  logic        clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, br_taken = 1'b0;
  logic [31:0] instr = 32'h0050_0093;
  logic        ir_we, pc_we, pc_sel, target_we, addr_we, mem_req, mem_we, mem_addr_sel;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic        reg_we, wb_sel, illegal;
  logic [3:0]  state_o;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  int checks = 0, fails = 0;
  logic mon_on = 1'b0;
  typedef struct packed {
    logic [7:0] cyc, irwe, pcwe, pcsel, tgt, addr, req, sel, we, rw, wb, dec, imm, zer, op2, op1;
  } rec_t;
  rec_t q[$];
  localparam logic [31:0] ADDI = 32'h0050_0093, LW = 32'h0040_A103, SW = 32'h0020_A223;
  localparam logic [31:0] BEQ = 32'h0000_0063, ADD0 = 32'h0020_8033, BAD = 32'h0000_007F;
  logic [31:0] cur = ADDI;
  mc_control #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .target_we(target_we), .addr_we(addr_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal),
`ifdef PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .state_o(state_o)
  );
  always #5 clk = ~clk;
  wire [6:0] en  = {ir_we, pc_we, target_we, addr_we, mem_req, mem_we, reg_we};
  wire [8:0] sel = {pc_sel, mem_addr_sel, alu_src_a, alu_src_b, alu_op, wb_sel};
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask
  task automatic drv(input logic r, input logic b, input logic [31:0] ni);
    @(posedge clk);
    #1;
    instr = ni;
    mem_ready = r;
    br_taken = b;
  endtask
  task automatic step(input logic r, input logic b, input logic [31:0] ni, input int st);
    drv(r, b, ni);
    @(negedge clk);
    chk("state", 32'(state_o), st);
  endtask
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  // instruction-level expectation: cycle count after fetch and per-signal activity totals
  function automatic rec_t model(input int t, input int mw, input logic tk, input logic rdnz);
    rec_t e;
    logic ld, st, mem, alu, br;
    ld = t == 0; st = t == 1; mem = t < 2; alu = t == 2 || t == 3; br = t == 4;
    e = '0;
    e.cyc   = 8'(ld ? 4 + mw : st ? 3 + mw : alu ? 3 : 2);
    e.pcwe  = 8'(br & tk);
    e.pcsel = 8'(br);
    e.tgt   = 8'd1;
    e.addr  = 8'(mem);
    e.req   = 8'(mem ? 1 + mw : 0);
    e.sel   = e.req;
    e.we    = 8'(st ? 1 + mw : 0);
    e.rw    = 8'((ld | alu) & rdnz);
    e.wb    = 8'(ld);
    e.dec   = 8'd1;
    e.imm   = 8'(mem) + 8'(t == 2);
    e.zer   = e.cyc - e.dec - e.imm;
    e.op2   = 8'(alu);
    e.op1   = 8'(br);
    return e;
  endfunction
  // monitor: accumulate activity per instruction, compare against the queue when FETCH returns
  initial begin
    rec_t acc, e;
    logic open;
    acc = '0;
    open = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on && rst_n) begin
        if (state_o != 4'd0) begin
          open = 1'b1;
          acc.cyc   += 8'd1;
          acc.irwe  += 8'(ir_we);
          acc.pcwe  += 8'(pc_we);
          acc.pcsel += 8'(pc_sel);
          acc.tgt   += 8'(target_we);
          acc.addr  += 8'(addr_we);
          acc.req   += 8'(mem_req);
          acc.sel   += 8'(mem_addr_sel);
          acc.we    += 8'(mem_we);
          acc.rw    += 8'(reg_we);
          acc.wb    += 8'(wb_sel);
          acc.dec   += 8'(alu_src_a == 2'd2 && alu_src_b == 2'd1);
          acc.imm   += 8'(alu_src_a == 2'd0 && alu_src_b == 2'd1);
          acc.zer   += 8'(alu_src_a == 2'd0 && alu_src_b == 2'd0);
          acc.op2   += 8'(alu_op == 2'b10);
          acc.op1   += 8'(alu_op == 2'b01);
        end else begin
          chk("fetch_ir_we", 32'(ir_we), 32'(mem_ready));
          chk("fetch_pc_we", 32'(pc_we), 32'(mem_ready));
          chk("fetch_mem", {30'd0, mem_req, mem_addr_sel}, 32'd2);
          if (open) begin
            checks++;
            if (q.size() == 0) begin
              fails++;
              $display("FAIL rec at %0t: got=%h exp=none", $time, acc);
            end else begin
              e = q.pop_front();
              if (acc !== e) begin
                fails++;
                $display("FAIL rec at %0t: got=%h exp=%h", $time, acc, e);
              end
            end
            chk("no_illegal", 32'(illegal), 32'd0);
            acc = '0;
            open = 1'b0;
          end
        end
      end
    end
  end
  initial begin
    // reset held 3 cycles with mem_ready high: everything quiet
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, ADDI);
      @(negedge clk);
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
    end
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    drv(1'b1, 1'b0, ADDI);
    rst_n = 1'b1;
    @(negedge clk);
    chk("addi_fetch_state", 32'(state_o), 32'd0);
    chk("addi_fetch_we", {29'd0, ir_we, pc_we, reg_we}, 32'd6);
    step(1'b0, 1'b0, ADDI, 1);
    chk("addi_dec", {29'd0, target_we, reg_we, pc_we}, 32'd4);
    step(1'b0, 1'b0, ADDI, 6);
    chk("addi_exec", {29'd0, reg_we, alu_op}, 32'd2);
    step(1'b0, 1'b0, ADDI, 8);
    chk("addi_wb", {30'd0, reg_we, wb_sel}, 32'd2);
    // randomized instruction stream against the scoreboard
    for (int n = 0; n < 150; n++) begin
      int t, fw, mw;
      logic tk;
      logic [4:0] rd;
      logic [6:0] opc;
      logic [31:0] ni;
      t  = int'($urandom_range(0, 4));
      fw = int'($urandom_range(0, 2));
      mw = int'($urandom_range(0, 3));
      tk = rb();
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      opc = (t == 0) ? 7'h03 : (t == 1) ? 7'h23 : (t == 2) ? 7'h13 : (t == 3) ? 7'h33 : 7'h63;
      ni = ($urandom & 32'hFFFF_F000) | {20'd0, rd, opc};
      for (int k = 0; k < fw; k++) drv(1'b0, rb(), cur);
      drv(1'b1, rb(), cur);
      mon_on = 1'b1;
      cur = ni;
      q.push_back(model(t, mw, tk, rd != 5'd0));
      drv(rb(), rb(), cur);
      if (t < 2) begin
        drv(rb(), rb(), cur);
        for (int k = 0; k < mw; k++) drv(1'b0, rb(), cur);
        drv(1'b1, rb(), cur);
        if (t == 0) drv(rb(), rb(), cur);
      end else if (t < 4) begin
        drv(rb(), rb(), cur);
        drv(rb(), rb(), cur);
      end else drv(rb(), tk, cur);
    end
    drv(1'b0, 1'b0, cur);
    @(negedge clk);
    #1;
    mon_on = 1'b0;
    chk("drain", 32'(q.size()), 32'd0);
    // lw with two wait cycles in MEM_RD
    step(1'b1, 1'b0, cur, 0);
    chk("lw_fetch", 32'(ir_we), 32'd1);
    step(1'b0, 1'b0, LW, 1);
    step(1'b0, 1'b0, LW, 2);
    chk("lw_addr_we", 32'(addr_we), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(i == 2, 1'b0, LW, 3);
      chk("lw_rd_hold", {29'd0, mem_req, mem_addr_sel, mem_we}, 32'd6);
    end
    step(1'b0, 1'b0, LW, 4);
    chk("lw_wb", {30'd0, wb_sel, reg_we}, 32'd3);
    // taken then not-taken beq
    step(1'b1, 1'b0, LW, 0);
    step(1'b0, 1'b0, BEQ, 1);
    step(1'b0, 1'b1, BEQ, 9);
    chk("beq_taken", {30'd0, pc_we, pc_sel}, 32'd3);
    step(1'b1, 1'b0, BEQ, 0);
    step(1'b0, 1'b0, BEQ, 1);
    step(1'b1, 1'b0, BEQ, 9);
    chk("beq_not_taken", {30'd0, pc_we, pc_sel}, 32'd1);
    // add x0 never writes the register file
    step(1'b1, 1'b0, BEQ, 0);
    step(1'b0, 1'b0, ADD0, 1);
    step(1'b0, 1'b0, ADD0, 7);
    step(1'b0, 1'b0, ADD0, 8);
    chk("add_x0_reg_we", 32'(reg_we), 32'd0);
    // illegal opcode parks in TRAP until reset
    step(1'b1, 1'b0, ADD0, 0);
    step(1'b0, 1'b0, BAD, 1);
    chk("bad_dec_illegal", 32'(illegal), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, BAD, 10);
      chk("trap_quiet", {24'd0, illegal, en}, 32'h80);
    end
    drv(1'b1, 1'b1, BAD);
    rst_n = 1'b0;
    @(negedge clk);
    chk("trap_rst_en", 32'(en), 32'd0);
    drv(1'b0, 1'b0, SW);
    rst_n = 1'b1;
    @(negedge clk);
    chk("trap_exit", {27'd0, illegal, state_o}, 32'd0);
    // reset during a store wait abandons the write
    step(1'b1, 1'b0, SW, 0);
    step(1'b0, 1'b0, SW, 1);
    step(1'b0, 1'b0, SW, 2);
    step(1'b0, 1'b0, SW, 5);
    chk("sw_wait", {30'd0, mem_req, mem_we}, 32'd3);
    drv(1'b0, 1'b0, SW);
    rst_n = 1'b0;
    @(negedge clk);
    chk("sw_rst", {30'd0, mem_req, mem_we}, 32'd0);
    drv(1'b1, 1'b0, SW);
    rst_n = 1'b1;
    @(negedge clk);
    chk("sw_rst_state", 32'(state_o), 32'd0);
`ifdef PERF_CNT_EN
    chk("cnt_rst", cycle_cnt | instret_cnt, 32'd0);
`endif
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, ADDI, 1);
      step(1'b0, 1'b0, ADDI, 6);
      step(1'b0, 1'b0, ADDI, 8);
      step(i == 0, 1'b0, ADDI, 0);
    end
`ifdef PERF_CNT_EN
    chk("instret", instret_cnt, 32'd2);
    chk("cycles", cycle_cnt, 32'd8);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multi-cycle main control FSM for the RV32I subset used by the core: lw, sw, I-type ALU, R-type ALU, and the six conditional branches. It sequences the shared ALU, the unified memory port, the register file and the immediate generator. It decodes instr[6:0] once per instruction in DECODE and drives every datapath enable and mux select. The datapath holds PC, OLD_PC, IR, TARGET and ADDR registers; this block only strobes their write enables.

Parameters:
CNT_W, 32, width of the performance counters (used only with PERF_CNT_EN).
ILLEGAL_HALT, 1, 1 = an unknown opcode parks the FSM in TRAP; 0 = an unknown opcode is retired as a NOP and the FSM returns to FETCH.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
instr  in  32  IR contents; only [6:0] and rd [11:7] are sampled
mem_ready  in  1  memory completes the current request this cycle
br_taken  in  1  ALU compare result for the current branch funct3
ir_we  out  1  load IR and OLD_PC from memory read data and PC
pc_we  out  1  PC write enable
pc_sel  out  1  PC source: 0 = ALU result, 1 = TARGET register
target_we  out  1  latch ALU result into TARGET
addr_we  out  1  latch ALU result into ADDR
mem_req  out  1  memory request
mem_we  out  1  memory write (valid only with mem_req)
mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ADDR
alu_src_a  out  2  ALU A select: 0 = rs1, 1 = PC, 2 = OLD_PC
alu_src_b  out  2  ALU B select: 0 = rs2, 1 = imm, 2 = constant 4
alu_op  out  2  ALU mode: 00 = add, 01 = branch compare, 10 = decode funct3/funct7
reg_we  out  1  register file write enable
wb_sel  out  1  writeback source: 0 = ALU, 1 = memory data
illegal  out  1  sticky illegal-opcode flag
state_o  out  4  current state encoding, for debug

Behaviour:
Reset:
- rst_n low at a rising edge sets state to FETCH and clears illegal.
- While rst_n is low, all enables (ir_we, pc_we, target_we, addr_we, mem_req, mem_we, reg_we) are forced to 0 combinationally.
- All selects are 0 during reset.
- Asserting reset mid-instruction abandons it: no register or memory write occurs in the reset cycle.

Output timing:
- Outputs are decoded from state (Moore).
- Exceptions: enables gated by mem_ready or br_taken are combinational on those inputs (Mealy).
- Any output not listed for a state is 0.

States, outputs and transitions:
- FETCH (0): mem_req=1, mem_addr_sel=0, alu_src_a=1, alu_src_b=2, alu_op=00. When mem_ready=1: ir_we=1 and pc_we=1 (PC <= PC+4), go to DECODE. When mem_ready=0: hold, all writes 0.
- DECODE (1): alu_src_a=2, alu_src_b=1, target_we=1 (TARGET <= OLD_PC+imm). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0010011 -> EXEC_I
  - 0110011 -> EXEC_R
  - 1100011 -> BRANCH
  - anything else -> TRAP if ILLEGAL_HALT=1, else FETCH; illegal is set to 1 in both cases.
- MEM_ADDR (2): alu_src_a=0, alu_src_b=1, alu_op=00, addr_we=1. Go to MEM_RD for a load, MEM_WR for a store.
- MEM_RD (3): mem_req=1, mem_addr_sel=1. Hold until mem_ready=1, then go to WB_MEM.
- WB_MEM (4): wb_sel=1, reg_we=(rd!=0). Go to FETCH.
- MEM_WR (5): mem_req=1, mem_we=1, mem_addr_sel=1. Hold until mem_ready=1, then go to FETCH.
- EXEC_I (6): alu_src_a=0, alu_src_b=1, alu_op=10. Go to WB_ALU.
- EXEC_R (7): alu_src_a=0, alu_src_b=0, alu_op=10. Go to WB_ALU.
- WB_ALU (8): wb_sel=0, reg_we=(rd!=0). Go to FETCH.
- BRANCH (9): alu_src_a=0, alu_src_b=0, alu_op=01. pc_we=br_taken and pc_sel=1. Go to FETCH.
- TRAP (10): all enables 0. Only reset exits this state.
- Encodings 11..15 are unreachable; if entered, go to FETCH next cycle with no side effects.

Latency with mem_ready tied high, from FETCH entry to the next FETCH entry:
- R-type and I-type: 4 cycles
- store: 4 cycles
- load: 5 cycles
- branch: 3 cycles
- Each memory wait cycle adds 1.

Boundaries:
- mem_req stays asserted and mem_addr_sel stays stable through any number of wait cycles.
- rd=x0 never produces a reg_we pulse.
- IR is written only in FETCH, so instr is stable from DECODE through writeback.

Optional Feature:
PERF_CNT_EN:
- When defined, adds two output ports: cycle_cnt [CNT_W-1:0] and instret_cnt [CNT_W-1:0].
- cycle_cnt increments on every cycle with rst_n high, including TRAP.
- instret_cnt increments on each transition into FETCH from WB_MEM, MEM_WR, WB_ALU or BRANCH, and from DECODE on an illegal opcode when ILLEGAL_HALT=0.
- Both counters wrap modulo 2^CNT_W and clear synchronously on reset.
- When undefined, the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset held 3 cycles, then released with mem_ready=1 and instr=addi x1,x0,5 (0x00500093) -> state sequence 0,1,6,8,0; reg_we=1 only in WB_ALU; pc_we pulses once in FETCH.
2. lw x2,4(x1) with mem_ready low for 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles with mem_req=1 and mem_addr_sel=1 throughout; WB_MEM has wb_sel=1 and reg_we=1; total 7 cycles.
3. beq with br_taken=1, then a second beq with br_taken=0 -> pc_we=1 and pc_sel=1 in the first BRANCH; pc_we=0 in the second; 3 cycles each.
4. add x0,x1,x2 (0x00208033) -> passes through WB_ALU with reg_we=0.
5. Opcode 0x7F with ILLEGAL_HALT=1 -> illegal=1, state_o=10 held for 20 cycles with all enables 0; rst_n low for 1 cycle returns state to FETCH and clears illegal.
6. Reset asserted during MEM_WR wait -> mem_we and mem_req are 0 in that cycle and state is FETCH next; with PERF_CNT_EN defined, both counters read 0 after reset, and instret_cnt=2 after two completed addi instructions.
